// File: rtl/sobel_window.sv
// sobel_window: 3x3 luma neighbourhood builder for the sobel block.
// Two circular line buffers plus per-row 3-tap shift registers.
module sobel_window #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int CW     = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    pixel_in,
  input  logic          pixel_valid,
  input  logic          sof,
  output logic [7:0]    z0,
  output logic [7:0]    z1,
  output logic [7:0]    z2,
  output logic [7:0]    z3,
  output logic [7:0]    z4,
  output logic [7:0]    z5,
  output logic [7:0]    z6,
  output logic [7:0]    z7,
  output logic [7:0]    z8,
  output logic          window_valid,
  output logic [CW-1:0] center_x,
  output logic [CW-1:0] center_y,
  output logic          frame_done
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] pos_c, pos_r;
  logic [AW-1:0] idx;
  logic [7:0]    lb1_q [WIDTH];
  logic [7:0]    lb2_q [WIDTH];
  logic [7:0]    lb1_rd, lb2_rd;
  logic [7:0]    win_q [9];
  logic          wv_q, wv_d;
  logic          fd_q, fd_d;
  logic [CW-1:0] cx_q, cy_q;

  // sof overrides the counters: the accepted pixel sits at (0,0)
  always_comb begin
    pos_c  = sof ? '0 : col_q;
    pos_r  = sof ? '0 : row_q;
    idx    = pos_c[AW-1:0];
    lb1_rd = lb1_q[idx];
    lb2_rd = lb2_q[idx];
  end

  // Raster position advance, end-of-frame and window-complete detection
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    fd_d  = 1'b0;
    wv_d  = 1'b0;
    if (pixel_valid) begin
      wv_d = (pos_c >= CW'(2)) && (pos_r >= CW'(2));
      if (pos_c == CW'(WIDTH - 1)) begin
        col_d = '0;
        if (pos_r == CW'(HEIGHT - 1)) begin
          row_d = '0;
          fd_d  = 1'b1;
        end else begin
          row_d = pos_r + 1'b1;
        end
      end else begin
        col_d = pos_c + 1'b1;
        row_d = pos_r;
      end
    end
  end

  // Line buffers: read old contents this cycle, shift the column down
  always_ff @(posedge clock) begin
    if (pixel_valid) begin
      lb2_q[idx] <= lb1_rd;
      lb1_q[idx] <= pixel_in;
    end
  end

  // Counters, window shift registers and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      wv_q  <= 1'b0;
      fd_q  <= 1'b0;
      cx_q  <= '0;
      cy_q  <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      wv_q  <= wv_d;
      fd_q  <= fd_d;
      if (pixel_valid) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= lb2_rd;
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= lb1_rd;
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= pixel_in;
        cx_q     <= pos_c - 1'b1;
        cy_q     <= pos_r - 1'b1;
      end
    end
  end

  assign z0           = win_q[0];
  assign z1           = win_q[1];
  assign z2           = win_q[2];
  assign z3           = win_q[3];
  assign z4           = win_q[4];
  assign z5           = win_q[5];
  assign z6           = win_q[6];
  assign z7           = win_q[7];
  assign z8           = win_q[8];
  assign window_valid = wv_q;
  assign frame_done   = fd_q;
  assign center_x     = cx_q;
  assign center_y     = cy_q;

endmodule

// File: tb/tb_sobel_window.sv
// tb_sobel_window: scoreboard bench for sobel_window.
// Pixel value at (r,c) is 16*r+c; expected windows derive from that.
module tb_sobel_window;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    pixel_in;
  logic          pixel_valid;
  logic          sof;
  logic [7:0]    z0, z1, z2, z3, z4, z5, z6, z7, z8;
  logic          window_valid;
  logic [CW-1:0] center_x, center_y;
  logic          frame_done;

  sobel_window #(.WIDTH(W), .HEIGHT(H), .CW(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .sof         (sof),
    .z0          (z0),
    .z1          (z1),
    .z2          (z2),
    .z3          (z3),
    .z4          (z4),
    .z5          (z5),
    .z6          (z6),
    .z7          (z7),
    .z8          (z8),
    .window_valid(window_valid),
    .center_x    (center_x),
    .center_y    (center_y),
    .frame_done  (frame_done)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int accepts = 0;
  int windows = 0;
  int fd_cnt  = 0;
  int fd_at [$];
  logic [91:0] sb [$];
  bit rnd_stall = 1'b0;

  task automatic check(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pv(input int r, input int c);
    return 8'(16 * r + c);
  endfunction

  function automatic logic [91:0] win(input int r, input int c);
    return {pv(r-2, c-2), pv(r-2, c-1), pv(r-2, c),
            pv(r-1, c-2), pv(r-1, c-1), pv(r-1, c),
            pv(r,   c-2), pv(r,   c-1), pv(r,   c),
            10'(c - 1), 10'(r - 1)};
  endfunction

  function automatic logic [91:0] obs();
    return {z0, z1, z2, z3, z4, z5, z6, z7, z8, center_x, center_y};
  endfunction

  task automatic post(input bit exp_wv, input bit exp_fd);
    logic [91:0] e;
    check("window_valid", 96'(window_valid), 96'(exp_wv));
    check("frame_done", 96'(frame_done), 96'(exp_fd));
    if (frame_done) begin
      fd_cnt++;
      fd_at.push_back(accepts);
    end
    if (window_valid) begin
      windows++;
      if (sb.size() == 0) begin
        check("sb_underflow", 96'(1), 96'(0));
      end else begin
        e = sb.pop_front();
        check("window", 96'(obs()), 96'(e));
      end
    end
  endtask

  task automatic idle();
    pixel_valid = 1'b0;
    pixel_in    = 8'($urandom);
    sof         = 1'($urandom);
    @(posedge clock);
    #1;
    post(1'b0, 1'b0);
  endtask

  task automatic px(input int r, input int c, input bit s);
    bit wv, fd;
    if (rnd_stall) begin
      for (int k = 0; k < 4 && $urandom_range(1, 0) == 1; k++) idle();
    end
    wv = (r >= 2) && (c >= 2);
    fd = (r == H - 1) && (c == W - 1);
    if (wv) sb.push_back(win(r, c));
    pixel_in    = pv(r, c);
    pixel_valid = 1'b1;
    sof         = s;
    @(posedge clock);
    #1;
    accepts++;
    post(wv, fd);
  endtask

  task automatic frame(input bit with_sof, input int last_r, input int last_c);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r > last_r || (r == last_r && c > last_c)) return;
        px(r, c, with_sof && r == 0 && c == 0);
      end
    end
  endtask

  task automatic zero_check(input string tag);
    check({tag, "_z"}, 96'(obs()), 96'(0));
    check({tag, "_wv"}, 96'(window_valid), 96'(0));
    check({tag, "_fd"}, 96'(frame_done), 96'(0));
  endtask

  task automatic sb_drain(input string tag);
    check({tag, "_sb_left"}, 96'(sb.size()), 96'(0));
    sb.delete();
    windows = 0;
    fd_cnt  = 0;
    fd_at.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [91:0] first_win;
    int d;
    reset       = 1'b1;
    pixel_valid = 1'b0;
    pixel_in    = '0;
    sof         = 1'b0;
    // 1: reset
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    zero_check("reset");
    idle();
    idle();
    zero_check("reset_idle");

    // 2: continuous frame
    frame(1'b1, H - 1, W - 1);
    check("s2_windows", 96'(windows), 96'(24));
    check("s2_fd_cnt", 96'(fd_cnt), 96'(1));
    check("s2_last_win", 96'(obs()), 96'(win(5, 7)));
    first_win = {8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12,
                 8'h20, 8'h21, 8'h22, 10'd1, 10'd1};
    check("s2_first_const", 96'(win(2, 2)), 96'(first_win));
    idle();
    sb_drain("s2");

    // 3: random stalls
    rnd_stall = 1'b1;
    frame(1'b1, H - 1, W - 1);
    rnd_stall = 1'b0;
    check("s3_windows", 96'(windows), 96'(24));
    check("s3_fd_cnt", 96'(fd_cnt), 96'(1));
    idle();
    sb_drain("s3");

    // 4: sof mid-frame at (3,4)
    frame(1'b1, 3, 3);
    sb_drain("s4_part");
    frame(1'b1, H - 1, W - 1);
    check("s4_windows", 96'(windows), 96'(24));
    check("s4_fd_cnt", 96'(fd_cnt), 96'(1));
    idle();
    sb_drain("s4");

    // 5: reset after (4,5), resume without sof
    frame(1'b1, 4, 5);
    sb_drain("s5_part");
    reset       = 1'b1;
    pixel_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    zero_check("s5_reset");
    frame(1'b0, H - 1, W - 1);
    check("s5_windows", 96'(windows), 96'(24));
    check("s5_fd_cnt", 96'(fd_cnt), 96'(1));
    idle();
    sb_drain("s5");

    // 6: two back-to-back frames
    frame(1'b1, H - 1, W - 1);
    frame(1'b1, H - 1, W - 1);
    check("s6_windows", 96'(windows), 96'(48));
    check("s6_fd_cnt", 96'(fd_cnt), 96'(2));
    d = (fd_at.size() == 2) ? fd_at[1] - fd_at[0] : -1;
    check("s6_fd_gap", 96'(d), 96'(48));
    idle();
    sb_drain("s6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
